// File: rtl/bp_fe_fetch_queue.sv
// FE output queue with per-fetch slot credits, flush and exception halt.
// Ports: clk_i/reset_i/flush_i, issue_v_i/issue_ready_o, enq_*_i, deq_*_o/deq_yumi_i.
module bp_fe_fetch_queue #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int fetch_width_p = 2,
  parameter int els_p = 4,
  parameter int branch_metadata_fwd_width_p = 36
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic flush_i,
  input  logic issue_v_i,
  output logic issue_ready_o,
  input  logic enq_v_i,
  input  logic enq_drop_i,
  input  logic enq_exception_i,
  input  logic [1:0] enq_ecode_i,
  input  logic [vaddr_width_p-1:0] enq_pc_i,
  input  logic [fetch_width_p*instr_width_p-1:0] enq_instr_i,
  input  logic [$clog2(fetch_width_p+1)-1:0] enq_count_i,
  input  logic [branch_metadata_fwd_width_p-1:0] enq_metadata_i,
  output logic deq_v_o,
  input  logic deq_yumi_i,
  output logic [vaddr_width_p-1:0] deq_pc_o,
  output logic [instr_width_p-1:0] deq_instr_o,
  output logic deq_exception_o,
  output logic [1:0] deq_ecode_o,
  output logic [branch_metadata_fwd_width_p-1:0] deq_metadata_o
);

  localparam int CW = $clog2(els_p+1);
  localparam int PW = $clog2(els_p);
  localparam int NW = $clog2(fetch_width_p+1);
  localparam int SW = (fetch_width_p > 1) ?
                      $clog2(fetch_width_p) : 1;
  localparam int VW = vaddr_width_p;
  localparam int IW = instr_width_p;
  localparam int MW = branch_metadata_fwd_width_p;

  typedef enum logic {e_wait, e_run} state_e;

  state_e r_state;
  state_e w_state_n;

  logic [CW-1:0] r_stored;
  logic [CW-1:0] r_out;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [SW-1:0] r_sub;

  logic [VW-1:0] r_pc [els_p];
  logic [fetch_width_p*IW-1:0] r_instr [els_p];
  logic [NW-1:0] r_cnt [els_p];
  logic r_exc [els_p];
  logic [1:0] r_ecode [els_p];
  logic [MW-1:0] r_meta [els_p];

  logic [CW:0] w_used;
  logic w_room;
  logic w_issue;
  logic w_ret;
  logic w_wr;
  logic w_yumi;
  logic w_last;
  logic w_pop;
  logic [NW-1:0] w_sub_p1;

  // Stored entries plus in-flight fetches may not exceed capacity.
  assign w_used = {1'b0, r_stored} + {1'b0, r_out};
  assign w_room = w_used < (CW+1)'(els_p);

  assign w_issue = issue_v_i & issue_ready_o;
  assign w_ret = enq_v_i | enq_drop_i;
  assign w_wr = enq_v_i & ~flush_i;
  assign w_yumi = deq_yumi_i & deq_v_o;
  assign w_sub_p1 = NW'(r_sub) + NW'(1);
  assign w_last = (w_sub_p1 == r_cnt[r_rd]);
  assign w_pop = w_yumi & w_last;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_wait;
    else r_state <= w_state_n;
  end

  // Flush wins over an exception landing in the same cycle.
  always_comb begin
    w_state_n = r_state;
    if (flush_i) w_state_n = e_run;
    else if (enq_v_i & enq_exception_i)
      w_state_n = e_wait;
  end

  always_comb begin
    issue_ready_o = (r_state == e_run) & ~flush_i & w_room;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_stored <= '0;
      r_out <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_sub <= '0;
    end else begin
      // Credits survive a flush; the producer still returns them.
      r_out <= r_out + CW'(w_issue) - CW'(w_ret);
      if (flush_i) begin
        r_stored <= '0;
        r_rd <= '0;
        r_wr <= '0;
        r_sub <= '0;
      end else begin
        r_stored <= r_stored + CW'(w_wr) - CW'(w_pop);
        if (w_wr) r_wr <= r_wr + PW'(1);
        if (w_pop) begin
          r_rd <= r_rd + PW'(1);
          r_sub <= '0;
        end else if (w_yumi) begin
          r_sub <= r_sub + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_pc[r_wr] <= enq_pc_i;
      r_instr[r_wr] <= enq_instr_i;
      r_cnt[r_wr] <= enq_exception_i ? NW'(1) : enq_count_i;
      r_exc[r_wr] <= enq_exception_i;
      r_ecode[r_wr] <= enq_ecode_i;
      r_meta[r_wr] <= enq_metadata_i;
    end
  end

  always_comb begin
    deq_v_o = (r_stored != '0) & ~flush_i;
    deq_pc_o = r_pc[r_rd] + VW'({r_sub, 2'b00});
    deq_instr_o = r_instr[r_rd][int'(r_sub)*IW +: IW];
    deq_exception_o = r_exc[r_rd];
    deq_ecode_o = r_ecode[r_rd];
    deq_metadata_o = r_meta[r_rd];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq_v_i && enq_drop_i));
      assert (!(w_ret && (r_out == '0)));
    end
  end

endmodule
